// File: rtl/rv32im_pkg.sv
// rv32im shared definitions: bus arbiter state encoding and Wishbone widths.
package rv32im_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int WB_SEL_W = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32im_rr_picker.sv
// Combinational round-robin selector: first requester above last,
// wrapping modulo N.
module rv32im_rr_picker
  import rv32im_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the nearest match wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N; i >= 1; i--) begin
      logic [IW-1:0] ci;
      ci = IW'((int'(last) + i) % N);
      if (req[ci]) begin
        valid = 1'b1;
        idx   = ci;
      end
    end
  end

endmodule

// File: rtl/rv32im_bus_arbiter.sv
// Round-robin Wishbone arbiter for rv32im masters sharing one slave.
// Optional strobe timeout: define RV32IM_ARBITER_TIMEOUT_EN.
module rv32im_bus_arbiter
  import rv32im_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_MASTERS-1:0]         req_i,
  output logic [NUM_MASTERS-1:0]         grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]    m_dat_i,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]         m_we_i,
  input  logic [NUM_MASTERS-1:0]         m_stb_i,
  output logic [XLEN-1:0]                m_dat_o,
  output logic [NUM_MASTERS-1:0]         m_ack_o,
  output logic [NUM_MASTERS-1:0]         m_err_o,
  output logic [XLEN-3:0]                adr_o,
  output logic [XLEN-1:0]                dat_o,
  output logic [WB_SEL_W-1:0]            sel_o,
  output logic                           we_o,
  output logic                           stb_o,
  output logic                           cyc_o,
  input  logic [XLEN-1:0]                dat_i,
  input  logic                           ack_i,
  input  logic                           err_i
);

  localparam int AW = XLEN - 2;
  localparam int SW = WB_SEL_W;
  localparam int IW = idx_w(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;
  logic                   own;
  logic                   tmo;

  rv32im_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req   (req_i),
    .last  (last_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_o <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_o <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_o;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d           = ARB_OWNED;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      ARB_OWNED: begin
        if (!req_i[owner_q]) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign own = (state_q == ARB_OWNED);

`ifdef RV32IM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign tmo = own && (cnt_q == CW'(TIMEOUT_CYCLES));

  // Counts stalled strobe cycles; any response or owner change restarts it.
  always_ff @(posedge clk_i) begin
    if (reset_i || ack_i || err_i || tmo || (state_q != state_d)) begin
      cnt_q <= '0;
    end else if (stb_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    adr_o   = '0;
    dat_o   = '0;
    sel_o   = '0;
    we_o    = 1'b0;
    stb_o   = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    if (own) begin
      adr_o            = m_adr_i[int'(owner_q)*AW +: AW];
      dat_o            = m_dat_i[int'(owner_q)*XLEN +: XLEN];
      sel_o            = m_sel_i[int'(owner_q)*SW +: SW];
      we_o             = m_we_i[owner_q];
      stb_o            = m_stb_i[owner_q] & grant_o[owner_q];
      m_ack_o[owner_q] = ack_i;
      m_err_o[owner_q] = err_i | tmo;
    end
  end

  assign cyc_o   = stb_o;
  assign m_dat_o = dat_i;

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Scoreboard bench for rv32im_bus_arbiter (two masters, 32-bit data).
module tb_rv32im_bus_arbiter;

  localparam int N  = 2;
  localparam int XL = 32;
  localparam int AW = XL - 2;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N-1:0]    req_i;
  logic [N-1:0]    grant_o;
  logic [N*AW-1:0] m_adr_i;
  logic [N*XL-1:0] m_dat_i;
  logic [N*4-1:0]  m_sel_i;
  logic [N-1:0]    m_we_i;
  logic [N-1:0]    m_stb_i;
  logic [XL-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;
  logic [AW-1:0]   adr_o;
  logic [XL-1:0]   dat_o;
  logic [3:0]      sel_o;
  logic            we_o;
  logic            stb_o;
  logic            cyc_o;
  logic [XL-1:0]   dat_i;
  logic            ack_i;
  logic            err_i;

  int vectors     = 0;
  int miscompares = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_v;

  always #5 clk_i = ~clk_i;

  rv32im_bus_arbiter #(
    .NUM_MASTERS    (N),
    .XLEN           (XL),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (req_i),
    .grant_o (grant_o),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_we_i  (m_we_i),
    .m_stb_i (m_stb_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .sel_o   (sel_o),
    .we_o    (we_o),
    .stb_o   (stb_o),
    .cyc_o   (cyc_o),
    .dat_i   (dat_i),
    .ack_i   (ack_i),
    .err_i   (err_i)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    req_i   = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    m_we_i  = '0;
    m_stb_i = '0;
    dat_i   = '0;
    ack_i   = 1'b0;
    err_i   = 1'b0;
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_grant got=%b exp=00", grant_o);
    end
    vectors++;
    if ({stb_o, cyc_o, we_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_stb_cyc_we got=%b exp=000", {stb_o, cyc_o, we_o});
    end
    vectors++;
    if ({m_ack_o, m_err_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ack_err got=%b exp=0000", {m_ack_o, m_err_o});
    end
    vectors++;
    if ({adr_o, dat_o, sel_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus got adr=%h dat=%h sel=%h exp=0", adr_o, dat_o, sel_o);
    end
  endtask

  task automatic test_grant();
    req_i          = 2'b01;
    m_adr_i[0+:AW]  = 30'h0001234;
    m_adr_i[AW+:AW] = 30'h3ff0000;
    settle();
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL grant_latency_c0 got=%b exp=00", grant_o);
    end
    step();
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL grant_c1 got=%b exp=01", grant_o);
    end
    vectors++;
    if (adr_o !== 30'h0001234 || stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL grant_route_idle got adr=%h stb=%b exp adr=0001234 stb=0", adr_o, stb_o);
    end
    m_stb_i       = 2'b01;
    m_we_i        = 2'b01;
    m_dat_i[31:0] = 32'hDEADBEEF;
    m_sel_i[3:0]  = 4'hF;
    settle();
    vectors++;
    if ({stb_o, cyc_o, we_o} !== 3'b111 || dat_o !== 32'hDEADBEEF || sel_o !== 4'hF) begin
      miscompares++;
      $display("FAIL grant_route_write got stb/cyc/we=%b dat=%h sel=%h exp 111 deadbeef f",
               {stb_o, cyc_o, we_o}, dat_o, sel_o);
    end
    ack_i = 1'b1;
    dat_i = 32'hCAFEF00D;
    settle();
    vectors++;
    if (m_ack_o !== 2'b01 || m_dat_o !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL grant_ack got ack=%b dat=%h exp ack=01 dat=cafef00d", m_ack_o, m_dat_o);
    end
    req_i   = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    ack_i   = 1'b0;
    step();
    vectors++;
    if (grant_o !== 2'b00 || stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL grant_release got grant=%b stb=%b exp 00 0", grant_o, stb_o);
    end
  endtask

  task automatic test_alternate();
    logic [N-1:0] t_req[7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    logic         t_ack[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] t_nxt[7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req_i   = t_req[i];
      m_stb_i = {1'b0, t_ack[i]};
      ack_i   = t_ack[i];
      settle();
      if (t_ack[i]) begin
        vectors++;
        if (m_ack_o !== 2'b01) begin
          miscompares++;
          $display("FAIL alt_ack cyc=%0d got=%b exp=01", i, m_ack_o);
        end
      end
      exp_q.push_back(t_nxt[i]);
      step();
      exp_v = exp_q.pop_front();
      vectors++;
      if (grant_o !== exp_v) begin
        miscompares++;
        $display("FAIL alt_grant cyc=%0d got=%b exp=%b", i + 1, grant_o, exp_v);
      end
    end
    m_stb_i = '0;
    ack_i   = 1'b0;
  endtask

  task automatic test_nonowner();
    m_adr_i[0+:AW]  = 30'h0001111;
    m_adr_i[AW+:AW] = 30'h2ABCDEF;
    m_stb_i         = 2'b01;
    settle();
    vectors++;
    if (grant_o !== 2'b10 || stb_o !== 1'b0 || adr_o !== 30'h2ABCDEF) begin
      miscompares++;
      $display("FAIL nonowner_stb got grant=%b stb=%b adr=%h exp 10 0 2abcdef",
               grant_o, stb_o, adr_o);
    end
    m_stb_i = 2'b11;
    settle();
    vectors++;
    if (stb_o !== 1'b1) begin
      miscompares++;
      $display("FAIL nonowner_owner_stb got=%b exp=1", stb_o);
    end
    ack_i = 1'b1;
    settle();
    vectors++;
    if (m_ack_o !== 2'b10) begin
      miscompares++;
      $display("FAIL nonowner_ack got=%b exp=10", m_ack_o);
    end
    ack_i = 1'b0;
    err_i = 1'b1;
    settle();
    vectors++;
    if (m_err_o !== 2'b10) begin
      miscompares++;
      $display("FAIL nonowner_err got=%b exp=10", m_err_o);
    end
    err_i   = 1'b0;
    req_i   = '0;
    m_stb_i = '0;
    step();
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL nonowner_release got=%b exp=00", grant_o);
    end
  endtask

  task automatic test_reset_mid();
    req_i = 2'b01;
    step();
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL rstmid_grant got=%b exp=01", grant_o);
    end
    m_stb_i = 2'b01;
    settle();
    vectors++;
    if (stb_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_stb_before got=%b exp=1", stb_o);
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    ack_i   = 1'b1;
    settle();
    vectors++;
    if (grant_o !== 2'b00 || stb_o !== 1'b0 || m_ack_o !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_after got grant=%b stb=%b ack=%b exp 00 0 00",
               grant_o, stb_o, m_ack_o);
    end
    ack_i   = 1'b0;
    req_i   = '0;
    m_stb_i = '0;
    step();
  endtask

  task automatic test_fairness();
    int model_last;
    int wins0;
    int wins1;
    do_reset();
    model_last = 1;
    wins0      = 0;
    wins1      = 0;
    for (int r = 0; r < 8; r++) begin
      req_i      = 2'b11;
      model_last = (model_last + 1) % N;
      exp_q.push_back((model_last == 0) ? 2'b01 : 2'b10);
      step();
      req_i = 2'b00;
      settle();
      exp_v = exp_q.pop_front();
      vectors++;
      if (grant_o !== exp_v) begin
        miscompares++;
        $display("FAIL fair_grant round=%0d got=%b exp=%b", r, grant_o, exp_v);
      end
      wins0 += int'(grant_o[0] === 1'b1);
      wins1 += int'(grant_o[1] === 1'b1);
      step();
    end
    vectors++;
    if (wins0 !== 4 || wins1 !== 4) begin
      miscompares++;
      $display("FAIL fair_count got m0=%0d m1=%0d exp 4 4", wins0, wins1);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_i = 2'b01;
    step();
    m_stb_i = 2'b01;
    for (int c = 1; c <= 10; c++) begin
`ifdef RV32IM_ARBITER_TIMEOUT_EN
      exp_q.push_back((c == 5 || c == 10) ? 2'b01 : 2'b00);
`else
      exp_q.push_back(2'b00);
`endif
      settle();
      exp_v = exp_q.pop_front();
      vectors++;
      if (m_err_o !== exp_v) begin
        miscompares++;
        $display("FAIL timeout_err cyc=%0d got=%b exp=%b", c, m_err_o, exp_v);
      end
      step();
    end
    err_i = 1'b1;
    settle();
    vectors++;
    if (m_err_o !== 2'b01) begin
      miscompares++;
      $display("FAIL err_mirror got=%b exp=01", m_err_o);
    end
    err_i   = 1'b0;
    m_stb_i = '0;
    req_i   = '0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_grant();
    test_alternate();
    test_nonowner();
    test_reset_mid();
    test_fairness();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
